i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Turns a single register-access request into the byte-level command
//   sequence for an I2C master (START / WR / RD / STOP), checks the slave
//   ACKs, and reports one completion pulse with an error code.
//
//   Optional feature macro: I2C_SEQ_REG16_EN
//     defined   -> two register-address bytes (reg_addr[15:8], then [7:0])
//     undefined -> one register-address byte  (reg_addr[7:0] only)
//
// Ports
//   clk, reset        system clock (rising edge), async active-low reset
//   req_*             request handshake and latched request fields
//   rsp_valid/rsp_err one-cycle completion pulse, 00 ok / 01 addr NACK / 10 reg-data NACK
//   rd_data           last byte read, held between requests
//   busy              high from acceptance through the rsp_valid cycle
//   m_*               byte-level I2C master command/status interface
module i2c_reg_sequencer #(
  parameter logic [15:0] I2C_DVSR = 16'd250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  slv_addr,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  wr_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [2:0]  m_cmd,
  output logic [7:0]  m_din,
  output logic        m_wr,
  output logic [15:0] m_dvsr,
  input  logic        m_ready,
  input  logic        m_done_tick,
  input  logic        m_ack,
  input  logic [7:0]  m_dout
);

  localparam logic [2:0] CMD_START = 3'b000;
  localparam logic [2:0] CMD_WR    = 3'b001;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [2:0] CMD_STOP  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_RDY, ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    SP_START, SP_ADDR_W, SP_REG_HI, SP_REG_LO, SP_DATA,
    SP_RSTART, SP_ADDR_R, SP_RD, SP_STOP
  } step_t;

  state_t      state_r, state_nxt;
  step_t       step_r, step_nxt, tgt_s;
  logic        load_s;
  logic        rw_r, rw_nxt;
  logic [6:0]  slv_r, slv_nxt;
  logic [7:0]  reg_lo_r, reg_lo_nxt;
  logic [7:0]  wdata_r, wdata_nxt;
  logic [1:0]  err_r, err_nxt;
  logic [7:0]  rd_data_r, rd_data_nxt;
  logic [2:0]  cmd_r, cmd_nxt;
  logic [7:0]  din_r, din_nxt;
`ifdef I2C_SEQ_REG16_EN
  logic [7:0]  reg_hi_r, reg_hi_nxt;
  logic        unused_inputs_s;
  // m_done_tick is only a progress hint; sequencing follows m_ready
  assign unused_inputs_s = m_done_tick;
`else
  logic        unused_inputs_s;
  // upper register byte and m_done_tick carry no function in this build
  assign unused_inputs_s = ^{reg_addr[15:8], m_done_tick};
`endif

  // Master command code for each sequence step
  function automatic logic [2:0] step_cmd(input step_t s);
    case (s)
      SP_START, SP_RSTART: step_cmd = CMD_START;
      SP_RD:               step_cmd = CMD_RD;
      SP_STOP:             step_cmd = CMD_STOP;
      default:             step_cmd = CMD_WR;
    endcase
  endfunction

  // Steps whose slave ACK must be checked
  function automatic logic step_is_wr(input step_t s);
    case (s)
      SP_ADDR_W, SP_REG_HI, SP_REG_LO, SP_DATA, SP_ADDR_R: step_is_wr = 1'b1;
      default:                                             step_is_wr = 1'b0;
    endcase
  endfunction

  // Successor step on the normal (all-ACK) path
  function automatic step_t follow_step(input step_t s, input logic rw);
    case (s)
      SP_START:  follow_step = SP_ADDR_W;
`ifdef I2C_SEQ_REG16_EN
      SP_ADDR_W: follow_step = SP_REG_HI;
`else
      SP_ADDR_W: follow_step = SP_REG_LO;
`endif
      SP_REG_HI: follow_step = SP_REG_LO;
      SP_REG_LO: follow_step = rw ? SP_RSTART : SP_DATA;
      SP_DATA:   follow_step = SP_STOP;
      SP_RSTART: follow_step = SP_ADDR_R;
      SP_ADDR_R: follow_step = SP_RD;
      default:   follow_step = SP_STOP;
    endcase
  endfunction

  // FSM state and sequencing registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      step_r    <= SP_START;
      rw_r      <= 1'b0;
      slv_r     <= 7'h00;
      reg_lo_r  <= 8'h00;
`ifdef I2C_SEQ_REG16_EN
      reg_hi_r  <= 8'h00;
`endif
      wdata_r   <= 8'h00;
      err_r     <= 2'b00;
      rd_data_r <= 8'h00;
      cmd_r     <= 3'b000;
      din_r     <= 8'h00;
    end else begin
      state_r   <= state_nxt;
      step_r    <= step_nxt;
      rw_r      <= rw_nxt;
      slv_r     <= slv_nxt;
      reg_lo_r  <= reg_lo_nxt;
`ifdef I2C_SEQ_REG16_EN
      reg_hi_r  <= reg_hi_nxt;
`endif
      wdata_r   <= wdata_nxt;
      err_r     <= err_nxt;
      rd_data_r <= rd_data_nxt;
      cmd_r     <= cmd_nxt;
      din_r     <= din_nxt;
    end
  end

  // Next-state, request latching, ACK checking and step selection
  always_comb begin
    state_nxt   = state_r;
    rw_nxt      = rw_r;
    slv_nxt     = slv_r;
    reg_lo_nxt  = reg_lo_r;
`ifdef I2C_SEQ_REG16_EN
    reg_hi_nxt  = reg_hi_r;
`endif
    wdata_nxt   = wdata_r;
    err_nxt     = err_r;
    rd_data_nxt = rd_data_r;
    load_s      = 1'b0;
    tgt_s       = step_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          rw_nxt     = req_rw;
          slv_nxt    = slv_addr;
          reg_lo_nxt = reg_addr[7:0];
`ifdef I2C_SEQ_REG16_EN
          reg_hi_nxt = reg_addr[15:8];
`endif
          wdata_nxt  = wr_data;
          err_nxt    = 2'b00;
          tgt_s      = SP_START;
          load_s     = 1'b1;
          state_nxt  = ST_ISSUE;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) state_nxt = ST_WAIT_BUSY;
        else         state_nxt = ST_ISSUE;
      end
      ST_WAIT_BUSY: begin
        if (!m_ready) state_nxt = ST_WAIT_RDY;
        else          state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_RDY: begin
        if (!m_ready) begin
          state_nxt = ST_WAIT_RDY;
        end else if (step_r == SP_STOP) begin
          state_nxt = ST_DONE;
        end else if (step_is_wr(step_r) && m_ack) begin
          // NACK: abandon the remaining bytes but still release the bus
          err_nxt   = ((step_r == SP_ADDR_W) || (step_r == SP_ADDR_R)) ? 2'b01 : 2'b10;
          tgt_s     = SP_STOP;
          load_s    = 1'b1;
          state_nxt = ST_ISSUE;
        end else begin
          if (step_r == SP_RD) rd_data_nxt = m_dout;
          else                 rd_data_nxt = rd_data_r;
          tgt_s     = follow_step(step_r, rw_r);
          load_s    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command/data byte for the step being loaded
  always_comb begin
    step_nxt = step_r;
    cmd_nxt  = cmd_r;
    din_nxt  = din_r;
    if (load_s) begin
      step_nxt = tgt_s;
      cmd_nxt  = step_cmd(tgt_s);
      case (tgt_s)
        SP_ADDR_W: din_nxt = {slv_r, 1'b0};
`ifdef I2C_SEQ_REG16_EN
        SP_REG_HI: din_nxt = reg_hi_r;
`endif
        SP_REG_LO: din_nxt = reg_lo_r;
        SP_DATA:   din_nxt = wdata_r;
        SP_ADDR_R: din_nxt = {slv_r, 1'b1};
        SP_RD:     din_nxt = 8'h01;  // master NACKs the single read byte
        default:   din_nxt = 8'h00;
      endcase
    end else begin
      step_nxt = step_r;
      cmd_nxt  = cmd_r;
      din_nxt  = din_r;
    end
  end

  // m_wr fires in the ISSUE cycle the master is ready, so it is gated by m_ready
  assign m_wr      = (state_r == ST_ISSUE) && m_ready;
  assign m_cmd     = cmd_r;
  assign m_din     = din_r;
  assign m_dvsr    = I2C_DVSR;
  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = (state_r == ST_DONE);
  assign rsp_err   = err_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
module tb_i2c_reg_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [6:0]  slv_addr = 7'h00;
  logic [15:0] reg_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic [7:0]  rd_data;
  logic        busy;
  logic [2:0]  m_cmd;
  logic [7:0]  m_din;
  logic        m_wr;
  logic [15:0] m_dvsr;
  logic        m_ready;
  logic        m_done_tick;
  logic        m_ack;
  logic [7:0]  m_dout;

  int total = 0;
  int bad = 0;

  i2c_reg_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .slv_addr(slv_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rd_data(rd_data), .busy(busy),
    .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr), .m_dvsr(m_dvsr),
    .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // ---------------- byte-level master model ----------------
  logic [10:0] log_seq [256];
  int          log_n = 0;
  int          base = 0;
  int          nack_idx = -1;
  logic [7:0]  cur_rd = 8'h00;
  int          cnt = 0;
  logic        ack_pend = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ready     <= 1'b1;
      m_ack       <= 1'b0;
      m_dout      <= 8'h00;
      m_done_tick <= 1'b0;
      cnt         <= 0;
      ack_pend    <= 1'b0;
    end else begin
      m_done_tick <= 1'b0;
      if (m_wr) begin
        log_seq[log_n & 255] <= {m_cmd, m_din};
        log_n    <= log_n + 1;
        m_ready  <= 1'b0;
        cnt      <= 2;
        // RD always returns ack=1 (master NACK) so an RD-ack check would misfire
        ack_pend <= (m_cmd == 3'b010) ||
                    ((m_cmd == 3'b001) && ((log_n - base) == nack_idx));
      end else if (!m_ready) begin
        if (cnt == 0) begin
          m_ready     <= 1'b1;
          m_ack       <= ack_pend;
          m_dout      <= cur_rd;
          m_done_tick <= 1'b1;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  localparam logic [10:0] S = {3'b000, 8'h00};
  localparam logic [10:0] P = {3'b011, 8'h00};
  localparam logic [10:0] R = {3'b010, 8'h01};
  localparam logic [10:0] Z = 11'h000;
  function automatic logic [10:0] W(input logic [7:0] d);
    W = {3'b001, d};
  endfunction

  // exp_seq[7] is the first command issued, exp_seq[0] the eighth
  typedef struct packed {
    logic            rw;
    logic [6:0]      slv;
    logic [15:0]     ra;
    logic [7:0]      wd;
    int              nack;
    logic [7:0]      rv;
    logic [1:0]      err;
    logic            chk_rd;
    int              n;
    logic [7:0][10:0] exp_seq;
  } vec_t;

  function automatic vec_t mk(input logic rw, input logic [6:0] slv, input logic [15:0] ra,
                              input logic [7:0] wd, input int nack, input logic [7:0] rv,
                              input logic [1:0] err, input logic chk_rd, input int n,
                              input logic [7:0][10:0] sq);
    mk.rw = rw; mk.slv = slv; mk.ra = ra; mk.wd = wd; mk.nack = nack; mk.rv = rv;
    mk.err = err; mk.chk_rd = chk_rd; mk.n = n; mk.exp_seq = sq;
  endfunction

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic got;
    v = vecs[i];
    got = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d req_ready before", i), {31'b0, req_ready}, 32'd1);
    base      = log_n;
    nack_idx  = v.nack;
    cur_rd    = v.rv;
    req_valid = 1'b1;
    req_rw    = v.rw;
    slv_addr  = v.slv;
    reg_addr  = v.ra;
    wr_data   = v.wd;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d busy after accept", i), {31'b0, busy}, 32'd1);
    // junk request held during the transaction: must be ignored and not latched
    req_rw   = ~v.rw;
    slv_addr = 7'h7F;
    reg_addr = 16'hFFFF;
    wr_data  = 8'hFF;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    chk($sformatf("v%0d rsp_valid seen", i), {31'b0, got}, 32'd1);
    if (got) begin
      chk($sformatf("v%0d rsp_err", i), {30'b0, rsp_err}, {30'b0, v.err});
      chk($sformatf("v%0d busy at rsp", i), {31'b0, busy}, 32'd1);
      chk($sformatf("v%0d cmd count", i), log_n - base, v.n);
      for (int k = 0; k < v.n && k < 8; k++)
        chk($sformatf("v%0d cmd%0d {cmd,din}", i, k), {21'b0, log_seq[(base + k) & 255]},
            {21'b0, v.exp_seq[7 - k]});
      if (v.chk_rd) chk($sformatf("v%0d rd_data", i), {24'b0, rd_data}, {24'b0, v.rv});
    end
  endtask

  initial begin
    vecs[0] = mk(1'b0, 7'h50, 16'h0010, 8'hA5, -1, 8'h00, 2'b00, 1'b0,
`ifdef I2C_SEQ_REG16_EN
                 6, {S, W(8'hA0), W(8'h00), W(8'h10), W(8'hA5), P, Z, Z});
`else
                 5, {S, W(8'hA0), W(8'h10), W(8'hA5), P, Z, Z, Z});
`endif
    vecs[1] = mk(1'b1, 7'h50, 16'h0010, 8'h00, -1, 8'h3C, 2'b00, 1'b1,
`ifdef I2C_SEQ_REG16_EN
                 8, {S, W(8'hA0), W(8'h00), W(8'h10), S, W(8'hA1), R, P});
`else
                 7, {S, W(8'hA0), W(8'h10), S, W(8'hA1), R, P, Z});
`endif
    vecs[2] = mk(1'b0, 7'h50, 16'h0010, 8'hA5, 1, 8'h00, 2'b01, 1'b0,
                 3, {S, W(8'hA0), P, Z, Z, Z, Z, Z});
`ifdef I2C_SEQ_REG16_EN
    vecs[3] = mk(1'b0, 7'h50, 16'h0010, 8'hA5, 4, 8'h00, 2'b10, 1'b0,
                 6, {S, W(8'hA0), W(8'h00), W(8'h10), W(8'hA5), P, Z, Z});
    vecs[4] = mk(1'b0, 7'h50, 16'h1234, 8'h5A, -1, 8'h00, 2'b00, 1'b0,
                 6, {S, W(8'hA0), W(8'h12), W(8'h34), W(8'h5A), P, Z, Z});
    vecs[5] = mk(1'b1, 7'h2A, 16'h0007, 8'h00, 2, 8'h00, 2'b10, 1'b0,
                 4, {S, W(8'h54), W(8'h00), P, Z, Z, Z, Z});
    vecs[6] = mk(1'b1, 7'h11, 16'h00FE, 8'h00, -1, 8'hC3, 2'b00, 1'b1,
                 8, {S, W(8'h22), W(8'h00), W(8'hFE), S, W(8'h23), R, P});
    vecs[7] = mk(1'b1, 7'h50, 16'h0010, 8'h00, 5, 8'h00, 2'b01, 1'b0,
                 7, {S, W(8'hA0), W(8'h00), W(8'h10), S, W(8'hA1), P, Z});
`else
    vecs[3] = mk(1'b0, 7'h50, 16'h0010, 8'hA5, 3, 8'h00, 2'b10, 1'b0,
                 5, {S, W(8'hA0), W(8'h10), W(8'hA5), P, Z, Z, Z});
    vecs[4] = mk(1'b0, 7'h50, 16'h1234, 8'h5A, -1, 8'h00, 2'b00, 1'b0,
                 5, {S, W(8'hA0), W(8'h34), W(8'h5A), P, Z, Z, Z});
    vecs[5] = mk(1'b1, 7'h2A, 16'h0007, 8'h00, 2, 8'h00, 2'b10, 1'b0,
                 4, {S, W(8'h54), W(8'h07), P, Z, Z, Z, Z});
    vecs[6] = mk(1'b1, 7'h11, 16'h00FE, 8'h00, -1, 8'hC3, 2'b00, 1'b1,
                 7, {S, W(8'h22), W(8'hFE), S, W(8'h23), R, P, Z});
    vecs[7] = mk(1'b1, 7'h50, 16'h0010, 8'h00, 4, 8'h00, 2'b01, 1'b0,
                 6, {S, W(8'hA0), W(8'h10), S, W(8'hA1), P, Z, Z});
`endif

    // reset state
    #12;
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset m_wr", {31'b0, m_wr}, 32'd0);
    chk("m_dvsr", {16'b0, m_dvsr}, 32'd250);
    @(negedge clk);
    reset = 1'b1;

    // back-to-back: each vector is presented the cycle after the previous rsp_valid
    for (int i = 0; i < 8; i++) run_vec(i);

    // reset while the register byte is in flight
    begin
      logic hit;
      hit = 1'b0;
      @(negedge clk);
      base      = log_n;
      nack_idx  = -1;
      req_valid = 1'b1;
      req_rw    = 1'b0;
      slv_addr  = 7'h50;
      reg_addr  = 16'h0010;
      wr_data   = 8'hA5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (log_n - base == 3) begin
          hit = 1'b1;
          break;
        end
      end
      chk("midreset reached reg byte", {31'b0, hit}, 32'd1);
      reset = 1'b0;
      #1;
      chk("midreset req_ready", {31'b0, req_ready}, 32'd1);
      chk("midreset busy", {31'b0, busy}, 32'd0);
      chk("midreset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("midreset rsp_err", {30'b0, rsp_err}, 32'd0);
      chk("midreset rd_data", {24'b0, rd_data}, 32'd0);
      chk("midreset m_wr", {31'b0, m_wr}, 32'd0);
      chk("midreset m_cmd", {29'b0, m_cmd}, 32'd0);
      chk("midreset m_din", {24'b0, m_din}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (rsp_valid) hit = 1'b1;
      end
      chk("midreset no rsp_valid", {31'b0, hit}, 32'd0);
      chk("midreset no stop issued", log_n - base, 32'd3);
    end

    // recovery after the abandoned transaction
    run_vec(1);
    @(negedge clk);
    chk("final req_ready", {31'b0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
